// File: rtl/tmp_sample_fifo.sv
// TMP sample FIFO: buffers DEPTH sensor samples and presents the oldest one as a registered 32-bit word.
// Define TMP_SIGN_EXT_EN to sign-extend samples on out (zero-extension otherwise).
module tmp_sample_fifo #(
    parameter int IN_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr,
    input  logic [IN_W-1:0] in,
    input  logic            rd,
    input  logic            clr_flags,
    output logic [31:0]     out,
    output logic [31:0]     status,
    output logic            empty,
    output logic            full
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [IN_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] head_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after_pop;
    logic [CNT_W-1:0] count_next;
    logic             ovf;
    logic             udf;
    logic             do_push;
    logic             do_pop;
    logic [31:0]      out_next;

    function automatic logic [31:0] extend(input logic [IN_W-1:0] sample);
`ifdef TMP_SIGN_EXT_EN
        return 32'($signed(sample));
`else
        return 32'(sample);
`endif
    endfunction

    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign status = {6'd0, udf, ovf, 6'd0, full, empty, {(16-CNT_W){1'b0}}, count};

    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop          = rd && !empty;
        do_push         = wr && (!full || do_pop);
        count_after_pop = do_pop ? count - CNT_W'(1) : count;
        count_next      = do_push ? count_after_pop + CNT_W'(1) : count_after_pop;
        head_next       = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        out_next        = 32'd0;
        if (count_next != '0) begin
            // The new head is this cycle's sample when nothing older survives the pop.
            if (count_after_pop == '0) begin
                out_next = extend(in);
            end else begin
                out_next = extend(mem[head_next]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            out    <= 32'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= head_next;
            count  <= count_next;
            out    <= out_next;
        end
    end

    // Sticky flags; a set event in the same cycle overrides clr_flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (clr_flags) begin
                ovf <= 1'b0;
                udf <= 1'b0;
            end
            if (wr && full && !rd) begin
                ovf <= 1'b1;
            end
            if (rd && empty) begin
                udf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tmp_sample_fifo.sv
// Directed self-checking bench for tmp_sample_fifo (DEPTH=4, IN_W=8).
module tb_tmp_sample_fifo;

    logic        clk;
    logic        rst;
    logic        wr;
    logic [7:0]  din;
    logic        rd;
    logic        clr_flags;
    logic [31:0] dout;
    logic [31:0] status;
    logic        empty;
    logic        full;

    int tests_run;
    int tests_failed;

    tmp_sample_fifo #(.IN_W(8), .DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .wr(wr),
        .in(din),
        .rd(rd),
        .clr_flags(clr_flags),
        .out(dout),
        .status(status),
        .empty(empty),
        .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs; returns 1 time unit after the rising edge.
    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic c);
        wr        = w;
        din       = d;
        rd        = r;
        clr_flags = c;
        @(posedge clk);
        #1;
        wr        = 1'b0;
        rd        = 1'b0;
        clr_flags = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (dout !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out: got %h, expected %h", dout, 32'h0);
        end
        tests_run++;
        if (status !== 32'h0001_0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_status: got %h, expected %h", status, 32'h0001_0000);
        end
        tests_run++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_empty_full: got %b%b, expected 10", empty, full);
        end
    endtask

    task automatic test_push_pop();
        logic [31:0] exp_out [4];
        exp_out[0] = 32'h1A;
        exp_out[1] = 32'h1B;
        exp_out[2] = 32'h1C;
        exp_out[3] = 32'h00;
        do_reset();
        applyStimulus(1'b1, 8'h19, 1'b0, 1'b0);
        tests_run++;
        if (dout !== 32'h19) begin
            tests_failed++;
            $display("[TB] FAIL first_push_out: got %h, expected %h", dout, 32'h19);
        end
        applyStimulus(1'b1, 8'h1A, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h1B, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h1C, 1'b0, 1'b0);
        tests_run++;
        if (full !== 1'b1 || status[2:0] !== 3'd4 || dout !== 32'h19) begin
            tests_failed++;
            $display("[TB] FAIL fill_four: got full=%b cnt=%0d out=%h, expected full=1 cnt=4 out=19",
                     full, status[2:0], dout);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            tests_run++;
            if (dout !== exp_out[i]) begin
                tests_failed++;
                $display("[TB] FAIL pop_%0d_out: got %h, expected %h", i, dout, exp_out[i]);
            end
        end
        tests_run++;
        if (empty !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL drained_empty: got %b, expected 1", empty);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        applyStimulus(1'b1, 8'h19, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h1A, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h1B, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h1C, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        tests_run++;
        if (status !== 32'h0102_0004) begin
            tests_failed++;
            $display("[TB] FAIL ovf_status: got %h, expected %h", status, 32'h0102_0004);
        end
        tests_run++;
        if (dout !== 32'h19) begin
            tests_failed++;
            $display("[TB] FAIL ovf_out: got %h, expected %h", dout, 32'h19);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        tests_run++;
        if (dout !== 32'h1A || status !== 32'h0100_0003) begin
            tests_failed++;
            $display("[TB] FAIL ovf_pop: got out=%h status=%h, expected out=1a status=01000003", dout, status);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        tests_run++;
        if (status !== 32'h0000_0003) begin
            tests_failed++;
            $display("[TB] FAIL ovf_clear: got %h, expected %h", status, 32'h0000_0003);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        tests_run++;
        if (dout !== 32'h1C) begin
            tests_failed++;
            $display("[TB] FAIL ovf_no_dropped_sample: got %h, expected %h", dout, 32'h1C);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_out [4];
        exp_out[0] = 32'h1B;
        exp_out[1] = 32'h1C;
        exp_out[2] = 32'h20;
        exp_out[3] = 32'h00;
        do_reset();
        applyStimulus(1'b1, 8'h19, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h1A, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h1B, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h1C, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h20, 1'b1, 1'b0);
        tests_run++;
        if (status !== 32'h0002_0004) begin
            tests_failed++;
            $display("[TB] FAIL full_push_pop_status: got %h, expected %h", status, 32'h0002_0004);
        end
        tests_run++;
        if (dout !== 32'h1A) begin
            tests_failed++;
            $display("[TB] FAIL full_push_pop_out: got %h, expected %h", dout, 32'h1A);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            tests_run++;
            if (dout !== exp_out[i]) begin
                tests_failed++;
                $display("[TB] FAIL wrap_pop_%0d_out: got %h, expected %h", i, dout, exp_out[i]);
            end
        end
        tests_run++;
        if (status !== 32'h0001_0000) begin
            tests_failed++;
            $display("[TB] FAIL wrap_drained_status: got %h, expected %h", status, 32'h0001_0000);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        tests_run++;
        if (status !== 32'h0201_0000 || dout !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL udf_set: got status=%h out=%h, expected status=02010000 out=0", status, dout);
        end
        applyStimulus(1'b1, 8'h30, 1'b1, 1'b0);
        tests_run++;
        if (status !== 32'h0200_0001 || dout !== 32'h30) begin
            tests_failed++;
            $display("[TB] FAIL empty_push_pop: got status=%h out=%h, expected status=02000001 out=30", status, dout);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        tests_run++;
        if (status !== 32'h0201_0000 || dout !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL udf_drain: got status=%h out=%h, expected status=02010000 out=0", status, dout);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        tests_run++;
        if (status !== 32'h0201_0000) begin
            tests_failed++;
            $display("[TB] FAIL udf_set_beats_clear: got %h, expected %h", status, 32'h0201_0000);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        tests_run++;
        if (status !== 32'h0001_0000) begin
            tests_failed++;
            $display("[TB] FAIL udf_clear: got %h, expected %h", status, 32'h0001_0000);
        end
    endtask

    task automatic test_sign_ext_and_midreset();
        logic [31:0] exp_f6;
`ifdef TMP_SIGN_EXT_EN
        exp_f6 = 32'hFFFF_FFF6;
`else
        exp_f6 = 32'h0000_00F6;
`endif
        do_reset();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hF6, 1'b0, 1'b0);
        tests_run++;
        if (dout !== exp_f6) begin
            tests_failed++;
            $display("[TB] FAIL extend_f6: got %h, expected %h", dout, exp_f6);
        end
        applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
        tests_run++;
        if (status !== 32'h0200_0003) begin
            tests_failed++;
            $display("[TB] FAIL hold_three_status: got %h, expected %h", status, 32'h0200_0003);
        end
        rst = 1'b1;
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        rst = 1'b0;
        tests_run++;
        if (status !== 32'h0001_0000 || dout !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL midburst_reset: got status=%h out=%h, expected status=00010000 out=0", status, dout);
        end
        applyStimulus(1'b1, 8'h42, 1'b0, 1'b0);
        tests_run++;
        if (dout !== 32'h42 || status !== 32'h0000_0001) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_push: got out=%h status=%h, expected out=42 status=00000001", dout, status);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        wr           = 1'b0;
        rd           = 1'b0;
        clr_flags    = 1'b0;
        din          = 8'h00;
        test_reset();
        test_push_pop();
        test_overflow();
        test_back_to_back();
        test_underflow();
        test_sign_ext_and_midreset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tmp_sample_fifo.md
Name: tmp_sample_fifo

Overview:
Parametrised successor to the TMP peripheral's single data register. It buffers DEPTH temperature samples written by the sensor-side logic and presents the oldest sample to the CPU bus as a 32-bit word. The CPU pops samples with a read strobe. A 32-bit status word exposes the fill level plus sticky overflow and underflow flags. The block sits between the TMP sensor interface and the peripheral's bus register decode.

Parameters:
IN_W, 8, sample width in bits; legal range 1..32.
DEPTH, 4, number of sample slots; power of two, at least 2.
CNT_W, $clog2(DEPTH)+1, fill-counter width; derived, not overridden.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  synchronous active-high reset, sampled on the rising edge of clk.
wr  in  1  push strobe from the sensor side; one sample per cycle while high.
in  in  IN_W  sample data, qualified by wr.
rd  in  1  pop strobe from the CPU bus decode; one pop per cycle while high.
clr_flags  in  1  clears the sticky ovf and udf flags.
out  out  32  oldest stored sample, extended to 32 bits; 0 when empty.
status  out  32  {6'd0, udf, ovf, 6'd0, full, empty, (16-CNT_W)'d0, count}.
empty  out  1  count == 0.
full  out  1  count == DEPTH.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset, synchronous: read and write pointers = 0, count = 0, ovf = 0, udf = 0, out = 0.
  - Resulting outputs: empty = 1, full = 0, status = 32'h0001_0000.
  - Sample storage is not reset; its contents are don't-care.
  - Reset in the middle of a burst discards every stored sample.
- Push (wr=1, not full): store `in` at the write pointer, advance the pointer modulo DEPTH, count+1.
- Pop (rd=1, not empty): advance the read pointer modulo DEPTH, count-1.
- Simultaneous wr and rd:
  - Not empty: pop and push in the same cycle; count unchanged. Allowed even when full; no overflow is raised.
  - Empty: the pop is ignored and udf is set; the push proceeds.
- wr while full, without rd: the sample is dropped, storage is unchanged, ovf is set.
- rd while empty: no state change except udf is set.
- ovf and udf are sticky and cleared only by clr_flags or rst. If clr_flags and a set event occur in the same cycle, the set wins.
- out is registered, with one-cycle latency:
  - After the edge that writes the first sample into an empty FIFO, out shows that sample.
  - After the edge that pops, out shows the next-oldest sample, or 0 if the FIFO became empty.
  - There is no combinational bypass from `in` to out.
- Extension of the IN_W-bit sample to 32 bits: zero-extension by default; see Optional Feature.
- Pointer wrap-around is modulo DEPTH with no skipped slots. count saturates neither above DEPTH nor below 0, because the guards above prevent it.
- empty, full and status are derived combinationally from the registered count and flags, so they are glitch-free relative to clk.

Optional Feature:
TMP_SIGN_EXT_EN
- Defined: out is the sign-extension of the stored IN_W-bit sample, treated as two's complement (e.g. 8'hF6 reads as 32'hFFFF_FFF6, i.e. -10 °C).
- Undefined: out is zero-extended (8'hF6 reads as 32'h0000_00F6).
- The value 0 shown when empty is unaffected in both cases.

Test Plan:
Common bench configuration: DEPTH=4, IN_W=8, macro undefined unless stated.
1. Reset then idle -> out=0, status=32'h0001_0000, empty=1, full=0.
2. Push 8'h19, 8'h1A, 8'h1B, 8'h1C on consecutive cycles -> full=1, status[2:0]=4, out=32'h19; then pop four times -> out shows 1A, 1B, 1C, then 0; empty=1.
3. Fill with 4 samples, then wr of 8'h55 without rd -> sample dropped, ovf=1, status=32'h0102_0004; one pop returns 8'h1A next (not 55); clr_flags -> ovf=0.
4. Full FIFO, wr=1 and rd=1 with in=8'h20 -> count stays 4, no ovf; after four further pops the last sample read is 8'h20, confirming wrap-around.
5. Empty FIFO: rd alone -> udf=1, count stays 0; wr=1 and rd=1 with in=8'h30 -> count=1, out=32'h30; same-cycle clr_flags and rd on empty -> udf remains 1.
6. Macro defined: push 8'hF6 -> out=32'hFFFF_FFF6. Additionally, assert rst while holding 3 samples -> next cycle count=0, out=0, flags cleared.
